mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multi-cycle MIPS control sequencer driving the shared-memory, single-ALU multi-cycle datapath. Decodes the latched instruction's opcode and func fields, then walks a Moore state machine through fetch, decode, execute, memory and writeback. Each step asserts the datapath's mux selects, register/PC/IR enables and ALU operation. Replaces the combinational single-cycle controller when the CPU is built in multi-cycle form.

## Interface
- `MEM_LAT_MAX`, default 15: watchdog bound on consecutive wait cycles per memory access. Active only with `MEM_WAIT_EN`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 6: Instruction[31:26] from the datapath IR. Stable from DECODE until instruction end.
- `func` in 6: Instruction[5:0] from the datapath IR.
- `Zero` in 1: ALU zero flag, same cycle.
- `mem_ready` in 1: memory completes the access this cycle. Used only with `MEM_WAIT_EN`.
- `pc_en` out 1: PC load enable; unconditional or branch-resolved.
- `IorD` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemRead`, `MemWrite`, `IRWrite`, `RegWrite` out 1 each.
- `RegDst` out 1: 1 = rd, 0 = rt.
- `MemToReg` out 1: 1 = MDR, 0 = ALUOut.
- `IsJal` out 1: write PC into $31.
- `IsLui` out 1: write imm<<16.
- `ALUsrcA` out 1: 0 = PC, 1 = register A.
- `ALUsrcB` out 2: 00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- `PCselect` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = register A.
- `ALUop` out 4: ADD 0000, SUB 0001, AND 0010, OR 0011, SLT 0100.
- `instr_done` out 1: one-cycle pulse in the final state of every instruction.
- `illegal_op` out 1: one-cycle pulse in DECODE for an unsupported encoding.
- `mem_timeout` out 1: sticky; set when the watchdog expires. Exists only with `MEM_WAIT_EN`.

## Operation
- Supported R-type (opcode 0x00), by func: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt, 0x08 jr.
- Supported I-type, by opcode: 0x08 addi, 0x0A slti, 0x0C andi, 0x0F lui, 0x23 lw, 0x2B sw, 0x04 beq, 0x05 bne.
- Supported J-type, by opcode: 0x02 j, 0x03 jal.
- FETCH: MemRead, IorD=0, IRWrite, ALUsrcA=0, ALUsrcB=01, ALUop=ADD, PCselect=00, pc_en. Next state DECODE.
- DECODE: ALUsrcA=0, ALUsrcB=11, ALUop=ADD (precomputes the branch target). Dispatches on opcode/func.
- MEM_ADDR: ALUsrcA=1, ALUsrcB=10, ADD. Next MEM_RD for lw, MEM_WR for sw.
- MEM_RD: MemRead, IorD=1. Next MEM_WB.
- MEM_WB: RegWrite, RegDst=0, MemToReg=1, done.
- MEM_WR: MemWrite, IorD=1, done.
- R_EXEC: ALUsrcA=1, ALUsrcB=00, ALUop from func. Next R_WB.
- R_WB: RegWrite, RegDst=1, MemToReg=0, done.
- I_EXEC: ALUsrcA=1, ALUsrcB=10, ALUop from opcode (addi ADD, slti SLT, andi AND). Next I_WB.
- I_WB: RegWrite, RegDst=0, MemToReg=0, done.
- BRANCH: ALUsrcA=1, ALUsrcB=00, SUB, PCselect=01.
  - pc_en = Zero for beq, !Zero for bne.
  - done.
- JUMP: PCselect=10, pc_en, done.
- JAL: PCselect=10, pc_en, RegWrite, IsJal, done.
- JR: PCselect=11, pc_en, done.
- LUI_WB: RegWrite, RegDst=0, IsLui, done.
- Every done state returns to FETCH.
- Illegal opcode or R-type func: DECODE pulses illegal_op, next FETCH. No register or memory write occurs; the PC has already advanced by 4.
- Outputs are Moore-decoded from state. The only exceptions are pc_en in BRANCH (depends on Zero) and memory-state gating (depends on mem_ready).

## Timing
- Reset: state = FETCH. Every output is 0 during any cycle with rst=1. The first fetch occurs in the first cycle after rst falls.
- rst asserted mid-instruction aborts it at the next edge. No partial write is issued in that cycle.
- CPI with zero-wait memory:
  - lw: 5.
  - R-type, addi/slti/andi, sw: 4.
  - beq, bne, j, jal, jr, lui: 3.
- instr_done is high exactly once per instruction, in its last cycle.
- Unconditional writes (RegWrite, MemWrite, pc_en outside BRANCH) are one cycle wide each.

## Configuration
- `MEM_WAIT_EN` defined: FETCH, MEM_RD and MEM_WR hold while mem_ready=0.
  - In FETCH, IRWrite and pc_en assert only in the cycle mem_ready=1.
  - MemRead/MemWrite stay high throughout the wait.
  - A counter aborts the access after MEM_LAT_MAX+1 consecutive wait cycles: sets mem_timeout, returns to FETCH, and performs no write for that access.
- `MEM_WAIT_EN` undefined: mem_ready is ignored, every memory state lasts exactly one cycle, and no counter or mem_timeout port exists.

## Structure
- Package `mc_ctrl_pkg` holds:
  - the state enum;
  - the ALUop codes;
  - the opcode and func constants;
  - the ALUsrcB and PCselect encodings.
- Sub-module `mc_alu_decoder`: combinational mapping from (state class, opcode, func) to ALUop, plus an R-type legality flag. Instantiated once.

## Test plan
- After reset, add $3,$1,$2 with $1=5, $2=7: states FETCH→DECODE→R_EXEC→R_WB. RegWrite is high only in cycle 4 and $3=12.
- lw with `MEM_WAIT_EN` and mem_ready low for 2 cycles in FETCH and 3 cycles in MEM_RD: instruction takes 10 cycles. IRWrite pulses once, RegWrite pulses once.
- beq with Zero=1, then bne with Zero=1: pc_en is high in BRANCH for beq only. Both take 3 cycles.
- jal at PC 0x40: $31 = 0x44, PC = the jump target, and IsJal and RegWrite are high in the same single cycle.
- Opcode 0x3F: illegal_op pulses in DECODE and the FSM returns to FETCH. No RegWrite or MemWrite is seen, and the PC has advanced by 4.
- rst raised in MEM_WR: MemWrite is 0 in that cycle and the FSM is in FETCH after rst falls.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and encodings for the multi-cycle MIPS control
// sequencer (state enum, ALU op codes, opcode/func values, mux encodings).
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13,
        S_LUI_WB   = 4'd14
    } state_t;

    // Which rule picks the ALU operation in the current state
    typedef enum logic [1:0] {
        CLS_ADD = 2'd0,
        CLS_SUB = 2'd1,
        CLS_R   = 2'd2,
        CLS_I   = 2'd3
    } alu_cls_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSEL_ALU    = 2'b00;
    localparam logic [1:0] PCSEL_ALUOUT = 2'b01;
    localparam logic [1:0] PCSEL_JUMP   = 2'b10;
    localparam logic [1:0] PCSEL_REGA   = 2'b11;

    // States that own the shared memory port
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder: maps (state class, opcode, func) to the ALU operation and
// flags which R-type func codes the sequencer supports.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  alu_cls_t   alu_cls,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output logic [3:0] alu_op,
    output logic       r_legal
);

    // Supported R-type func codes
    always_comb begin
        r_legal = 1'b0;
        case (func)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_JR: r_legal = 1'b1;
            default: r_legal = 1'b0;
        endcase
    end

    // ALU operation for the current state class
    always_comb begin
        alu_op = ALU_ADD;
        case (alu_cls)
            CLS_SUB: alu_op = ALU_SUB;
            CLS_R: begin
                case (func)
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            CLS_I: begin
                case (opcode)
                    OP_SLTI: alu_op = ALU_SLT;
                    OP_ANDI: alu_op = ALU_AND;
                    default: alu_op = ALU_ADD;
                endcase
            end
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: Moore control sequencer for the multi-cycle MIPS datapath.
// Optional macro MEM_WAIT_EN: memory states stall on mem_ready with a
// MEM_LAT_MAX watchdog and a sticky mem_timeout output.
//
// state    | meaning
// FETCH    | read instruction at PC, IR <= mem, PC <= PC+4
// DECODE   | precompute branch target, dispatch on opcode/func
// MEM_ADDR | ALUOut <= A + sext(imm)
// MEM_RD   | MDR <= mem[ALUOut]
// MEM_WB   | rt <= MDR (done)
// MEM_WR   | mem[ALUOut] <= B (done)
// R_EXEC   | ALUOut <= A op B
// R_WB     | rd <= ALUOut (done)
// I_EXEC   | ALUOut <= A op sext(imm)
// I_WB     | rt <= ALUOut (done)
// BRANCH   | compare A-B, PC <= target if taken (done)
// JUMP     | PC <= jump target (done)
// JAL      | $31 <= PC, PC <= jump target (done)
// JR       | PC <= A (done)
// LUI_WB   | rt <= imm<<16 (done)
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_LAT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       IsJal,
    output logic       IsLui,
    output logic       ALUsrcA,
    output logic [1:0] ALUsrcB,
    output logic [1:0] PCselect,
    output logic [3:0] ALUop,
`ifdef MEM_WAIT_EN
    output logic       mem_timeout,
`endif
    output logic       instr_done,
    output logic       illegal_op
);

    state_t     state, state_nx;
    alu_cls_t   alu_cls;
    logic [3:0] alu_op;
    logic       r_legal;
    logic       mem_go;
    logic       wait_tc;
    logic       dec_illegal;
    logic       pc_en_base;

    mc_alu_decoder u_alu_dec (
        .alu_cls (alu_cls),
        .opcode  (opcode),
        .func    (func),
        .alu_op  (alu_op),
        .r_legal (r_legal)
    );

`ifdef MEM_WAIT_EN
    localparam int CW = (MEM_LAT_MAX < 1) ? 1 : $clog2(MEM_LAT_MAX + 1);

    logic [CW-1:0] wait_cnt;
    logic          timeout_q;

    assign mem_go  = mem_ready;
    assign wait_tc = is_mem_state(state) && !mem_ready && (wait_cnt == '0);
    assign mem_timeout = timeout_q && !rst;

    // Watchdog: down-counts consecutive wait cycles, reloads on any progress
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= CW'(MEM_LAT_MAX);
            timeout_q <= 1'b0;
        end else begin
            if (is_mem_state(state) && !mem_ready && !wait_tc)
                wait_cnt <= wait_cnt - 1'b1;
            else
                wait_cnt <= CW'(MEM_LAT_MAX);
            if (wait_tc)
                timeout_q <= 1'b1;
        end
    end
`else
    localparam int unused_mem_lat = MEM_LAT_MAX;
    logic unused_mem_ready;

    assign unused_mem_ready = mem_ready;
    assign mem_go  = 1'b1;
    assign wait_tc = 1'b0;
`endif

    // ALU rule selection by state
    always_comb begin
        case (state)
            S_R_EXEC: alu_cls = CLS_R;
            S_I_EXEC: alu_cls = CLS_I;
            S_BRANCH: alu_cls = CLS_SUB;
            default:  alu_cls = CLS_ADD;
        endcase
    end

    // Next-state logic, including DECODE dispatch and watchdog abort
    always_comb begin
        state_nx    = state;
        dec_illegal = 1'b0;
        case (state)
            S_FETCH:    if (mem_go) state_nx = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: begin
                        if (!r_legal) begin
                            state_nx    = S_FETCH;
                            dec_illegal = 1'b1;
                        end else if (func == FN_JR) begin
                            state_nx = S_JR;
                        end else begin
                            state_nx = S_R_EXEC;
                        end
                    end
                    OP_LW, OP_SW:              state_nx = S_MEM_ADDR;
                    OP_ADDI, OP_SLTI, OP_ANDI: state_nx = S_I_EXEC;
                    OP_LUI:                    state_nx = S_LUI_WB;
                    OP_BEQ, OP_BNE:            state_nx = S_BRANCH;
                    OP_J:                      state_nx = S_JUMP;
                    OP_JAL:                    state_nx = S_JAL;
                    default: begin
                        state_nx    = S_FETCH;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: state_nx = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_go) state_nx = S_MEM_WB;
            S_MEM_WR:   if (mem_go) state_nx = S_FETCH;
            S_R_EXEC:   state_nx = S_R_WB;
            S_I_EXEC:   state_nx = S_I_WB;
            default:    state_nx = S_FETCH;
        endcase
        if (wait_tc)
            state_nx = S_FETCH;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_FETCH;
        else
            state <= state_nx;
    end

    // Moore output decode; everything forced low while rst is high
    always_comb begin
        pc_en_base = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 1'b0;
        MemToReg   = 1'b0;
        IsJal      = 1'b0;
        IsLui      = 1'b0;
        ALUsrcA    = 1'b0;
        ALUsrcB    = SRCB_B;
        PCselect   = PCSEL_ALU;
        ALUop      = alu_op;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (state)
            S_FETCH: begin
                MemRead    = 1'b1;
                IRWrite    = mem_go;
                ALUsrcB    = SRCB_FOUR;
                pc_en_base = mem_go;
            end
            S_DECODE: begin
                ALUsrcB    = SRCB_IMM_SH2;
                illegal_op = dec_illegal;
            end
            S_MEM_ADDR: begin
                ALUsrcA = 1'b1;
                ALUsrcB = SRCB_IMM;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite   = 1'b1;
                MemToReg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_go;
            end
            S_R_EXEC: ALUsrcA = 1'b1;
            S_R_WB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            S_I_EXEC: begin
                ALUsrcA = 1'b1;
                ALUsrcB = SRCB_IMM;
            end
            S_I_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUsrcA    = 1'b1;
                PCselect   = PCSEL_ALUOUT;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                PCselect   = PCSEL_JUMP;
                pc_en_base = 1'b1;
                instr_done = 1'b1;
            end
            S_JAL: begin
                PCselect   = PCSEL_JUMP;
                pc_en_base = 1'b1;
                RegWrite   = 1'b1;
                IsJal      = 1'b1;
                instr_done = 1'b1;
            end
            S_JR: begin
                PCselect   = PCSEL_REGA;
                pc_en_base = 1'b1;
                instr_done = 1'b1;
            end
            S_LUI_WB: begin
                RegWrite   = 1'b1;
                IsLui      = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            pc_en_base = 1'b0;
            IorD       = 1'b0;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            RegDst     = 1'b0;
            MemToReg   = 1'b0;
            IsJal      = 1'b0;
            IsLui      = 1'b0;
            ALUsrcA    = 1'b0;
            ALUsrcB    = SRCB_B;
            PCselect   = PCSEL_ALU;
            ALUop      = ALU_ADD;
            instr_done = 1'b0;
            illegal_op = 1'b0;
        end
    end

    // Branch resolution kept apart so Zero never feeds the Moore decode
    assign pc_en = pc_en_base ||
                   (!rst && (state == S_BRANCH) &&
                    ((opcode == OP_BEQ) ? Zero : !Zero));

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: runs a short MIPS program through a behavioral
// multi-cycle datapath steered by mc_control_fsm and checks CPI, write
// pulses and architectural results against hand-computed values.
module tb_mc_control_fsm;

    logic        clk;
    logic        rst;
    logic        load_prog;
    logic        mem_ready;
    logic [5:0]  opcode, func;
    logic        Zero;
    logic        pc_en, IorD, MemRead, MemWrite, IRWrite, RegWrite;
    logic        RegDst, MemToReg, IsJal, IsLui, ALUsrcA;
    logic [1:0]  ALUsrcB, PCselect;
    logic [3:0]  ALUop;
    logic        instr_done, illegal_op;
`ifdef MEM_WAIT_EN
    logic        mem_timeout;
    localparam int LW_CYC = 10;
`else
    localparam int LW_CYC = 5;
`endif

    mc_control_fsm #(.MEM_LAT_MAX(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .func       (func),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .MemToReg   (MemToReg),
        .IsJal      (IsJal),
        .IsLui      (IsLui),
        .ALUsrcA    (ALUsrcA),
        .ALUsrcB    (ALUsrcB),
        .PCselect   (PCselect),
        .ALUop      (ALUop),
`ifdef MEM_WAIT_EN
        .mem_timeout(mem_timeout),
`endif
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioral datapath ----------------
    logic [31:0] mem [0:255];
    logic [31:0] rf  [0:31];
    logic [31:0] pc, ir, mdr, a_reg, b_reg, alu_out;
    logic [31:0] addr, mem_rd, src_a, src_b, alu_res, sext, pc_nx, wb_data;
    logic [4:0]  wb_dst;

    assign opcode = ir[31:26];
    assign func   = ir[5:0];
    assign sext   = {{16{ir[15]}}, ir[15:0]};
    assign addr   = IorD ? alu_out : pc;
    assign mem_rd = mem[addr[9:2]];
    assign src_a  = ALUsrcA ? a_reg : pc;

    always_comb begin
        case (ALUsrcB)
            2'b00:   src_b = b_reg;
            2'b01:   src_b = 32'd4;
            2'b10:   src_b = sext;
            default: src_b = {sext[29:0], 2'b00};
        endcase
        case (ALUop)
            4'b0000: alu_res = src_a + src_b;
            4'b0001: alu_res = src_a - src_b;
            4'b0010: alu_res = src_a & src_b;
            4'b0011: alu_res = src_a | src_b;
            4'b0100: alu_res = ($signed(src_a) < $signed(src_b)) ? 32'd1 : 32'd0;
            default: alu_res = 32'hxxxx_xxxx;
        endcase
        case (PCselect)
            2'b00:   pc_nx = alu_res;
            2'b01:   pc_nx = alu_out;
            2'b10:   pc_nx = {pc[31:28], ir[25:0], 2'b00};
            default: pc_nx = a_reg;
        endcase
        wb_dst  = IsJal ? 5'd31 : (RegDst ? ir[15:11] : ir[20:16]);
        wb_data = IsJal ? pc : (IsLui ? {ir[15:0], 16'h0000} :
                                (MemToReg ? mdr : alu_out));
    end

    assign Zero = (alu_res == 32'd0);

    // Datapath registers; ALUOut/MDR hold while a data access is stalled
    always @(posedge clk) begin
        if (load_prog) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
            for (int i = 0; i < 32; i++)  rf[i]  <= 32'd0;
            rf[1]    <= 32'd5;
            rf[2]    <= 32'd7;
            mem[0]   <= 32'h00221820; // 0x00 add  $3,$1,$2
            mem[1]   <= 32'h8C040200; // 0x04 lw   $4,0x200($0)
            mem[2]   <= 32'hAC030204; // 0x08 sw   $3,0x204($0)
            mem[3]   <= 32'h2026FFFD; // 0x0C addi $6,$1,-3
            mem[4]   <= 32'h3C051234; // 0x10 lui  $5,0x1234
            mem[5]   <= 32'h10210002; // 0x14 beq  $1,$1,+2 -> 0x20
            mem[8]   <= 32'h14210002; // 0x20 bne  $1,$1,+2
            mem[9]   <= 32'hFC000000; // 0x24 opcode 0x3F
            mem[10]  <= 32'h08000010; // 0x28 j    0x40
            mem[16]  <= 32'h0C000040; // 0x40 jal  0x100
            mem[64]  <= 32'h03E00008; // 0x100 jr  $31
            mem[17]  <= 32'h00224024; // 0x44 and  $8,$1,$2
            mem[18]  <= 32'h28290006; // 0x48 slti $9,$1,6
            mem[19]  <= 32'h00415022; // 0x4C sub  $10,$2,$1
            mem[20]  <= 32'h0000003F; // 0x50 R-type func 0x3F
            mem[21]  <= 32'hAC060208; // 0x54 sw   $6,0x208($0)
            mem[128] <= 32'hDEADBEEF;
            pc <= 32'd0; ir <= 32'd0; mdr <= 32'd0;
            a_reg <= 32'd0; b_reg <= 32'd0; alu_out <= 32'd0;
        end else if (rst) begin
            pc <= 32'd0;
        end else begin
            a_reg <= rf[ir[25:21]];
            b_reg <= rf[ir[20:16]];
            if (!(IorD && !mem_ready)) alu_out <= alu_res;
            if (mem_ready) mdr <= mem_rd;
            if (IRWrite) ir <= mem_rd;
            if (pc_en) pc <= pc_nx;
            if (RegWrite && wb_dst != 5'd0) rf[wb_dst] <= wb_data;
            if (MemWrite && mem_ready) mem[addr[9:2]] <= b_reg;
        end
    end

    // ---------------- checking ----------------
    int n_vec  = 0;
    int n_miss = 0;
    int r_cyc, r_rw, r_rw_at, r_mw, r_irw, r_pce, r_ill, r_done, r_jal;

    localparam logic [31:0] FETCH_OUTS = 32'h0015_0100;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {11'd0, pc_en, IorD, MemRead, MemWrite, IRWrite, RegWrite,
                RegDst, MemToReg, IsJal, IsLui, ALUsrcA, ALUsrcB, PCselect,
                ALUop, instr_done, illegal_op};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH; bit k of rdy_mask is mem_ready in cycle k+1
    task automatic run_instr(input logic [31:0] rdy_mask);
        r_cyc = 0; r_rw = 0; r_rw_at = 0; r_mw = 0; r_irw = 0;
        r_pce = 0; r_ill = 0; r_done = 0; r_jal = 0;
        while (r_done == 0 && r_ill == 0 && r_cyc < 32) begin
            mem_ready = rdy_mask[r_cyc];
            #1;
            r_cyc++;
            if (RegWrite) begin r_rw++; r_rw_at = r_cyc; end
            if (MemWrite) r_mw++;
            if (IRWrite) r_irw++;
            if (pc_en) r_pce++;
            if (illegal_op) r_ill++;
            if (instr_done) r_done++;
            if (RegWrite && IsJal) r_jal++;
            tick();
        end
        mem_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int irw_wait;
        rst = 1'b1; load_prog = 1'b1; mem_ready = 1'b1;
        tick(); tick();
        load_prog = 1'b0;
        tick();
        check_val("rst_outs", outs(), 32'd0);
`ifdef MEM_WAIT_EN
        check_val("rst_timeout", {31'd0, mem_timeout}, 32'd0);
`endif
        rst = 1'b0;
        #1;
        check_val("first_fetch", outs(), FETCH_OUTS);

        run_instr(32'hFFFF_FFFF);                 // add
        check_val("add_cpi", r_cyc, 4);
        check_val("add_rw_cycle", r_rw_at, 4);
        check_val("add_rw_cnt", r_rw, 1);
        check_val("add_r3", rf[3], 32'd12);

`ifdef MEM_WAIT_EN
        run_instr(32'hFFFF_FF1C);                 // lw, 2+3 wait cycles
`else
        run_instr(32'hFFFF_FFFF);
`endif
        check_val("lw_cpi", r_cyc, LW_CYC);
        check_val("lw_irw_cnt", r_irw, 1);
        check_val("lw_rw_cnt", r_rw, 1);
        check_val("lw_r4", rf[4], 32'hDEADBEEF);

        run_instr(32'hFFFF_FFFF);                 // sw
        check_val("sw_cpi", r_cyc, 4);
        check_val("sw_mw_cnt", r_mw, 1);
        check_val("sw_mem", mem[129], 32'd12);

        run_instr(32'hFFFF_FFFF);                 // addi
        check_val("addi_cpi", r_cyc, 4);
        check_val("addi_r6", rf[6], 32'd2);

        run_instr(32'hFFFF_FFFF);                 // lui
        check_val("lui_cpi", r_cyc, 3);
        check_val("lui_r5", rf[5], 32'h1234_0000);

        run_instr(32'hFFFF_FFFF);                 // beq taken
        check_val("beq_cpi", r_cyc, 3);
        check_val("beq_pce_cnt", r_pce, 2);
        check_val("beq_pc", pc, 32'h20);

        run_instr(32'hFFFF_FFFF);                 // bne not taken
        check_val("bne_cpi", r_cyc, 3);
        check_val("bne_pce_cnt", r_pce, 1);
        check_val("bne_pc", pc, 32'h24);

        run_instr(32'hFFFF_FFFF);                 // opcode 0x3F
        check_val("ill_op_cnt", r_ill, 1);
        check_val("ill_op_cyc", r_cyc, 2);
        check_val("ill_op_writes", r_rw + r_mw + r_done, 0);
        check_val("ill_op_pc", pc, 32'h28);

        run_instr(32'hFFFF_FFFF);                 // j
        check_val("j_cpi", r_cyc, 3);
        check_val("j_pc", pc, 32'h40);

        run_instr(32'hFFFF_FFFF);                 // jal
        check_val("jal_cpi", r_cyc, 3);
        check_val("jal_r31", rf[31], 32'h44);
        check_val("jal_pc", pc, 32'h100);
        check_val("jal_same_cycle", r_jal, 1);
        check_val("jal_rw_cnt", r_rw, 1);

        run_instr(32'hFFFF_FFFF);                 // jr
        check_val("jr_cpi", r_cyc, 3);
        check_val("jr_pc", pc, 32'h44);

        run_instr(32'hFFFF_FFFF);                 // and
        check_val("and_r8", rf[8], 32'd5);
        run_instr(32'hFFFF_FFFF);                 // slti
        check_val("slti_r9", rf[9], 32'd1);
        run_instr(32'hFFFF_FFFF);                 // sub
        check_val("sub_r10", rf[10], 32'd2);

        run_instr(32'hFFFF_FFFF);                 // R-type func 0x3F
        check_val("ill_fn_cnt", r_ill, 1);
        check_val("ill_fn_writes", r_rw + r_mw, 0);
        check_val("ill_fn_pc", pc, 32'h54);

        // sw interrupted by reset in MEM_WR
        tick(); tick(); tick();
        check_val("memwr_reached", {31'd0, MemWrite}, 32'd1);
        rst = 1'b1;
        #1;
        check_val("rst_memwr", outs(), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check_val("post_rst_fetch", outs(), FETCH_OUTS);
        check_val("rst_no_write", mem[130], 32'd0);
        run_instr(32'hFFFF_FFFF);                 // add from PC 0
        check_val("post_rst_cpi", r_cyc, 4);

`ifdef MEM_WAIT_EN
        // FETCH of lw never gets mem_ready: watchdog fires after 16 waits
        irw_wait = 0;
        for (int i = 1; i <= 16; i++) begin
            mem_ready = 1'b0;
            #1;
            if (IRWrite) irw_wait++;
            if (i == 16) check_val("timeout_early", {31'd0, mem_timeout}, 32'd0);
            tick();
        end
        check_val("timeout_set", {31'd0, mem_timeout}, 32'd1);
        check_val("timeout_irw", irw_wait, 0);
        run_instr(32'hFFFF_FFFF);                 // retry lw without waits
        check_val("retry_lw_cpi", r_cyc, 5);
        check_val("timeout_sticky", {31'd0, mem_timeout}, 32'd1);
`else
        irw_wait = 0;
        check_val("lw_pc_before", pc, 32'h4 + irw_wait);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
